dds_step_sweeper: RTL and testbench

Frequency-sweep controller that sits directly upstream of the DDS generator and drives its `step` (phase-increment) input. On a start request it walks `step` from a start value to a stop value in fixed increments, holding each value for a programmable dwell. It supports one-shot sweeps and, optionally, continuous triangle sweeps. It runs on the same clock as the DDS phase accumulator, so every `step` change takes effect on the accumulator's next update.

---
 rtl/dds_step_sweeper.sv | 165 ++++++++++++++++
 tb/tb_dds_step_sweeper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_step_sweeper.sv
// dds_step_sweeper: walks the DDS phase increment from start_step to
// stop_step in inc-sized moves, holding each value for dwell+1 cycles.
// Optional feature macro: DDS_SWEEP_TRIANGLE_EN enables continuous
// triangle sweeps (mode=1); without it every sweep is one-shot and dir
// stays 0.
//
// state | meaning
// IDLE  | no sweep running, step holds its last value
// DWELL | sweep running, counting down the hold time of the current step
module dds_step_sweeper #(
  parameter int STEP_W  = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [STEP_W-1:0]  start_step,
  input  logic [STEP_W-1:0]  stop_step,
  input  logic [STEP_W-1:0]  inc,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t              state, state_n;
  logic [STEP_W-1:0]   step_n, target, target_n, sh_inc, sh_inc_n;
  logic [DWELL_W-1:0]  cnt, cnt_n, sh_dwell, sh_dwell_n;
  logic                busy_n, done_n, dir_n;

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic [STEP_W-1:0]   sh_start, sh_start_n, sh_stop, sh_stop_n;
  logic                sh_mode, sh_mode_n;
`else
  logic                unused_mode;
  assign unused_mode = mode;
`endif

  // One move toward tgt, saturating at tgt; the extra bit keeps the
  // arithmetic from wrapping past 0 or the top of the step range.
  function automatic logic [STEP_W-1:0] move_toward(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] tgt,
    input logic [STEP_W-1:0] amt
  );
    logic [STEP_W:0] sum;
    logic [STEP_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, amt};
    diff = {1'b0, cur} - {1'b0, amt};
    if (amt == '0)
      return tgt;
    else if (tgt > cur)
      return (sum >= {1'b0, tgt}) ? tgt : sum[STEP_W-1:0];
    else if (tgt < cur)
      return (diff[STEP_W] || (diff[STEP_W-1:0] <= tgt)) ? tgt : diff[STEP_W-1:0];
    else
      return cur;
  endfunction

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_n    = state;
    step_n     = step;
    target_n   = target;
    sh_inc_n   = sh_inc;
    sh_dwell_n = sh_dwell;
    cnt_n      = cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    dir_n      = dir;
`ifdef DDS_SWEEP_TRIANGLE_EN
    sh_start_n = sh_start;
    sh_stop_n  = sh_stop;
    sh_mode_n  = sh_mode;
`endif
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          sh_inc_n   = inc;
          sh_dwell_n = dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
          sh_start_n = start_step;
          sh_stop_n  = stop_step;
          sh_mode_n  = mode;
`endif
          step_n   = start_step;
          target_n = stop_step;
          dir_n    = 1'b0;
          busy_n   = 1'b1;
          cnt_n    = dwell;
          state_n  = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (step != target) begin
          step_n = move_toward(step, target, sh_inc);
          cnt_n  = sh_dwell;
        end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (sh_mode) begin
            // endpoint reached: bounce toward the other end right away
            target_n = dir ? sh_stop : sh_start;
            dir_n    = ~dir;
            step_n   = move_toward(step, target_n, sh_inc);
            cnt_n    = sh_dwell;
          end else begin
`else
          begin
`endif
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      target   <= '0;
      sh_inc   <= '0;
      sh_dwell <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir      <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      sh_start <= '0;
      sh_stop  <= '0;
      sh_mode  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      step     <= step_n;
      target   <= target_n;
      sh_inc   <= sh_inc_n;
      sh_dwell <= sh_dwell_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      dir      <= dir_n;
`ifdef DDS_SWEEP_TRIANGLE_EN
      sh_start <= sh_start_n;
      sh_stop  <= sh_stop_n;
      sh_mode  <= sh_mode_n;
`endif
    end
  end

endmodule

// File: tb/tb_dds_step_sweeper.sv
// Bench for dds_step_sweeper: expected per-cycle outputs are queued by the
// stimulus; a monitor pops one entry whenever busy or done is high.
module tb_dds_step_sweeper;

  logic        clk = 1'b0;
  logic        rst, start, stop, mode;
  logic [7:0]  start_step, stop_step, inc, step;
  logic [15:0] dwell;
  logic        busy, done, dir;

  always #5 clk = ~clk;

  dds_step_sweeper #(.STEP_W(8), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_step(start_step), .stop_step(stop_step), .inc(inc),
    .dwell(dwell), .mode(mode),
    .step(step), .busy(busy), .done(done), .dir(dir)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       b;
    logic       d;
    logic       r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_act, mon_exp;
  int   checks = 0;
  int   failures = 0;

  task automatic push(input logic [7:0] s, input logic b, input logic d, input logic r);
    exp_t e;
    e.s = s; e.b = b; e.d = d; e.r = r;
    sb.push_back(e);
  endtask

  task automatic push_hold(input logic [7:0] s, input int n, input logic r);
    for (int i = 0; i < n; i++) push(s, 1'b1, 1'b0, r);
  endtask

  // Monitor: every cycle the DUT shows busy or done must match the queue head.
  always @(negedge clk) begin
    if (busy || done) begin
      mon_act.s = step; mon_act.b = busy; mon_act.d = done; mon_act.r = dir;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got step=%0d busy=%0b done=%0b dir=%0b, nothing expected",
                 step, busy, done, dir);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL sb_compare: got step=%0d busy=%0b done=%0b dir=%0b, want step=%0d busy=%0b done=%0b dir=%0b",
                   mon_act.s, mon_act.b, mon_act.d, mon_act.r,
                   mon_exp.s, mon_exp.b, mon_exp.d, mon_exp.r);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d entries left want 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; start is sampled on the next edge (edge 0).
  task automatic begin_sweep(input logic [7:0] ss, input logic [7:0] es, input logic [7:0] in,
                             input logic [15:0] dw, input logic md);
    start_step = ss; stop_step = es; inc = in; dwell = dw; mode = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    start_step = '0; stop_step = '0; inc = '0; dwell = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_step", step, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dir", dir, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic upward sweep, dwell 2
    push_hold(10, 3, 0); push_hold(20, 3, 0); push_hold(30, 3, 0); push_hold(40, 3, 0);
    push(40, 0, 1, 0);
    begin_sweep(10, 40, 10, 2, 0);
    drain("up_dwell2");

    // saturate at top, no wrap
    push_hold(200, 1, 0); push_hold(220, 1, 0); push_hold(240, 1, 0); push_hold(255, 1, 0);
    push(255, 0, 1, 0);
    begin_sweep(200, 255, 20, 0, 0);
    drain("top_saturate");

    // downward, saturate at target without going below 0
    push_hold(100, 1, 0); push_hold(60, 1, 0); push_hold(20, 1, 0); push_hold(5, 1, 0);
    push(5, 0, 1, 0);
    begin_sweep(100, 5, 40, 0, 0);
    drain("down_sweep");

    // inc=0 jumps straight to the target
    push_hold(5, 2, 0); push_hold(50, 2, 0);
    push(50, 0, 1, 0);
    begin_sweep(5, 50, 0, 1, 0);
    drain("inc_zero");

    // start_step == stop_step one-shot: held dwell+1 then done
    push_hold(7, 4, 0);
    push(7, 0, 1, 0);
    begin_sweep(7, 7, 3, 3, 0);
    drain("equal_endpoints");

    // start re-asserted mid-sweep with new values is ignored
    push_hold(10, 3, 0); push_hold(20, 3, 0); push_hold(30, 3, 0); push_hold(40, 3, 0);
    push(40, 0, 1, 0);
    begin_sweep(10, 40, 10, 2, 0);
    start_step = 99; stop_step = 3; inc = 1; dwell = 0; mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("restart_ignored");

    // reset at edge 5 mid-sweep
    push_hold(10, 3, 0); push_hold(20, 2, 0);
    begin_sweep(10, 40, 10, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_step", step, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_queue", sb.size(), 0);
    sb.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start and stop together in IDLE: no sweep
    start_step = 77; stop_step = 90; inc = 1; dwell = 0; mode = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_step", step, 0);
    @(posedge clk);
    #1;

`ifdef DDS_SWEEP_TRIANGLE_EN
    // triangle 0..20, stop at edge 7
    push(0, 1, 0, 0); push(10, 1, 0, 0); push(20, 1, 0, 0);
    push(10, 1, 0, 1); push(0, 1, 0, 1);
    push(10, 1, 0, 0); push(20, 1, 0, 0);
    begin_sweep(0, 20, 10, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("tri_stop_busy", busy, 0);
    chk("tri_stop_step", step, 20);
    chk("tri_stop_done", done, 0);
    chk("tri_stop_dir", dir, 0);
    drain("triangle");
`else
    // mode=1 without triangle support is a plain one-shot
    push(0, 1, 0, 0); push(10, 1, 0, 0); push(20, 1, 0, 0);
    push(20, 0, 1, 0);
    begin_sweep(0, 20, 10, 0, 1);
    drain("mode1_oneshot");
    chk("mode1_dir", dir, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
